instr_seq: RTL and testbench

- Central control sequencer for the MSP430 datapath. Walks each instruction through fetch, decode, operand-fetch, execute and write-back.
- Drives memory-bus select, memory/register write strobes and load pulses to the register file, calc unit and MDB muxes.
- Sits beside instr_dec: instr_seq owns *when* each datapath step happens; instr_dec keeps combinational field decode.

---
 rtl/msp_ctrl_pkg.sv | 39 +++
 rtl/mem_wait_ctr.sv | 29 ++
 rtl/instr_seq.sv | 214 +++++++++++++++++++++
 tb/tb_instr_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/msp_ctrl_pkg.sv
// msp_ctrl_pkg: shared encodings for the MSP430 control sequencer.
// State codes, MAB_sel codes, the opcodes the sequencer special-cases, and the constant-generator registers.
package msp_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RSTV    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_SRC_EXT = 4'd3,
    ST_SRC_RD  = 4'd4,
    ST_DST_EXT = 4'd5,
    ST_DST_RD  = 4'd6,
    ST_EXEC    = 4'd7,
    ST_DST_WR  = 4'd8,
    ST_HALT    = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    MAB_PC   = 3'd0,
    MAB_CALC = 3'd1,
    MAB_SOUT = 3'd2,
    MAB_SP   = 3'd3,
    MAB_RST  = 3'd4
  } mab_sel_t;

  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_BIT = 4'hB;

  // R2 is a constant only for As=1x; R3 is a constant for every As.
  localparam logic [3:0] REG_CG1 = 4'd2;
  localparam logic [3:0] REG_CG2 = 4'd3;

  function automatic logic is_mem_state(input state_t s);
    return (s inside {ST_RSTV, ST_FETCH, ST_SRC_EXT, ST_SRC_RD,
                      ST_DST_EXT, ST_DST_RD, ST_DST_WR});
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// mem_wait_ctr: counts stalled memory cycles; timeout is combinational from the count (0 cycles).
// No backpressure of its own: clr wins over inc, timeout asserts at count WAIT_MAX-1.
module mem_wait_ctr #(
  parameter int WAIT_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign timeout = (cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/instr_seq.sv
// instr_seq: MSP430 control sequencer; strobes decode in the same cycle from state, IR and mem_rdy.
// Backpressure: memory states hold while mem_rdy=0 and bail to FETCH with bus_err after WAIT_MAX stalls.
module instr_seq
  import msp_ctrl_pkg::*;
#(
  parameter logic [15:0] RST_ADDR = 16'hFFFE,
  parameter int          WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        mem_rdy,
  input  logic        halt_req,
  output logic [3:0]  phase,
  output logic [2:0]  MAB_sel,
  output logic        MW,
  output logic        RW,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld_vec,
  output logic        ext_ld,
  output logic        src_autoinc,
  output logic        jmp_eval,
  output logic        instr_done,
  output logic        illegal,
  output logic        bus_err,
  output logic        halted
);

  if (RST_ADDR[0] != 1'b0 || WAIT_MAX < 2) begin : g_param_chk
    $error("instr_seq: RST_ADDR must be word aligned and WAIT_MAX at least 2");
  end

  state_t      state, state_nxt;
  mab_sel_t    mab;
  logic [15:0] ir;
  logic        ir_unused;

  logic [3:0] opc;
  logic [1:0] as_m;
  logic [3:0] rs;
  logic       ad, is_jmp, is_f1, is_f2;
  logic       src_cg, src_ext, src_mem, cmp_bit, dst_mem;
  logic       stall, timeout;
  state_t     post_src, retire_st;

  assign ir_unused = ir[6];

  assign opc    = ir[15:12];
  assign as_m   = ir[5:4];
  assign ad     = ir[7];
  assign is_jmp = (ir[15:13] == 3'b001);
  assign is_f1  = (ir[15:12] >= 4'h4);
  assign is_f2  = (ir[15:10] == 6'b000100) && !ir[9];
  assign rs     = is_f1 ? ir[11:8] : ir[3:0];

  assign src_cg  = (rs == REG_CG2) || ((rs == REG_CG1) && as_m[1]);
  assign src_ext = !src_cg && ((as_m == 2'b01) || ((as_m == 2'b11) && (rs == 4'd0)));
  assign src_mem = !src_cg && (as_m != 2'b00);
  assign cmp_bit = is_f1 && ((opc == OP_CMP) || (opc == OP_BIT));
  // Format II operates in place, so a memory source is also the write-back target.
  assign dst_mem = is_f1 ? ad : (as_m != 2'b00);

  assign post_src  = (is_f1 && ad) ? ST_DST_EXT : ST_EXEC;
  assign retire_st = halt_req ? ST_HALT : ST_FETCH;

  assign stall = is_mem_state(state) && !mem_rdy;

  mem_wait_ctr #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clr     (!stall || timeout),
    .inc     (stall),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RSTV;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (ir_ld) begin
        ir <= instr;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    mab         = MAB_PC;
    MW          = 1'b0;
    RW          = 1'b0;
    ir_ld       = 1'b0;
    pc_inc      = 1'b0;
    pc_ld_vec   = 1'b0;
    ext_ld      = 1'b0;
    src_autoinc = 1'b0;
    jmp_eval    = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;
    halted      = 1'b0;

    case (state)
      ST_RSTV: begin
        mab = MAB_RST;
        if (mem_rdy) begin
          pc_ld_vec = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_rdy) begin
          ir_ld     = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_jmp) begin
          state_nxt = ST_EXEC;
        end else if (is_f1 || is_f2) begin
          if (src_ext)      state_nxt = ST_SRC_EXT;
          else if (src_mem) state_nxt = ST_SRC_RD;
          else              state_nxt = post_src;
        end else begin
          illegal   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_SRC_EXT: begin
        if (mem_rdy) begin
          ext_ld    = 1'b1;
          pc_inc    = 1'b1;
          // Immediate operand is the extension word itself; no further read.
          state_nxt = (as_m == 2'b11) ? post_src : ST_SRC_RD;
        end
      end
      ST_SRC_RD: begin
        mab = (as_m == 2'b01) ? MAB_CALC : MAB_SOUT;
        if (mem_rdy) begin
          src_autoinc = (as_m == 2'b11);
          state_nxt   = post_src;
        end
      end
      ST_DST_EXT: begin
        if (mem_rdy) begin
          ext_ld    = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = (opc == OP_MOV) ? ST_EXEC : ST_DST_RD;
        end
      end
      ST_DST_RD: begin
        mab = MAB_CALC;
        if (mem_rdy) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_jmp) begin
          jmp_eval   = 1'b1;
          instr_done = 1'b1;
          state_nxt  = retire_st;
        end else begin
          RW = !dst_mem && !cmp_bit;
          if (dst_mem && !cmp_bit) begin
            state_nxt = ST_DST_WR;
          end else begin
            instr_done = 1'b1;
            state_nxt  = retire_st;
          end
        end
      end
      ST_DST_WR: begin
        mab = MAB_CALC;
        if (mem_rdy) begin
          MW         = 1'b1;
          instr_done = 1'b1;
          state_nxt  = retire_st;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) begin
          state_nxt = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_RSTV;
      end
    endcase

    if (stall && timeout) begin
      bus_err   = 1'b1;
      state_nxt = ST_FETCH;
    end

    // RSTV with mem_rdy high would otherwise strobe pc_ld_vec during reset.
    if (!rst) begin
      pc_ld_vec = 1'b0;
      ir_ld     = 1'b0;
      pc_inc    = 1'b0;
      halted    = 1'b0;
      bus_err   = 1'b0;
    end
  end

  assign phase   = state;
  assign MAB_sel = mab;

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: one cycle per step, outputs checked 1ns after the inputs change at negedge.
module tb_instr_seq;
  import msp_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        mem_rdy = 1'b0;
  logic        halt_req = 1'b0;
  logic [3:0]  phase;
  logic [2:0]  MAB_sel;
  logic MW, RW, ir_ld, pc_inc, pc_ld_vec, ext_ld, src_autoinc;
  logic jmp_eval, instr_done, illegal, bus_err, halted;
  logic [11:0] strobes;

  int checks = 0;
  int failures = 0;

  localparam logic [11:0] S_NONE = 12'h000;
  localparam logic [11:0] S_MW   = 12'h800;
  localparam logic [11:0] S_RW   = 12'h400;
  localparam logic [11:0] S_IR   = 12'h200;
  localparam logic [11:0] S_PCI  = 12'h100;
  localparam logic [11:0] S_VEC  = 12'h080;
  localparam logic [11:0] S_EXT  = 12'h040;
  localparam logic [11:0] S_AI   = 12'h020;
  localparam logic [11:0] S_JMP  = 12'h010;
  localparam logic [11:0] S_DONE = 12'h008;
  localparam logic [11:0] S_ILL  = 12'h004;
  localparam logic [11:0] S_BERR = 12'h002;
  localparam logic [11:0] S_HALT = 12'h001;

  instr_seq #(
    .RST_ADDR (16'hFFFE),
    .WAIT_MAX (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .mem_rdy     (mem_rdy),
    .halt_req    (halt_req),
    .phase       (phase),
    .MAB_sel     (MAB_sel),
    .MW          (MW),
    .RW          (RW),
    .ir_ld       (ir_ld),
    .pc_inc      (pc_inc),
    .pc_ld_vec   (pc_ld_vec),
    .ext_ld      (ext_ld),
    .src_autoinc (src_autoinc),
    .jmp_eval    (jmp_eval),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .bus_err     (bus_err),
    .halted      (halted)
  );

  assign strobes = {MW, RW, ir_ld, pc_inc, pc_ld_vec, ext_ld, src_autoinc,
                    jmp_eval, instr_done, illegal, bus_err, halted};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input state_t ph, input mab_sel_t mab,
                     input logic [11:0] st);
    checks++;
    assert (phase === 4'(ph) && MAB_sel === 3'(mab) && strobes === st)
    else begin
      failures++;
      $error("FAIL %s: got phase=%0d mab=%0d strobes=%b, want phase=%0d mab=%0d strobes=%b",
             tag, phase, MAB_sel, strobes, 4'(ph), 3'(mab), st);
    end
  endtask

  // Drive one cycle's inputs, check the decoded outputs, then move to the next negedge.
  task automatic cyc(input logic rdy, input logic hreq, input logic [15:0] ins,
                     input string tag, input state_t ph, input mab_sel_t mab,
                     input logic [11:0] st);
    mem_rdy  = rdy;
    halt_req = hreq;
    instr    = ins;
    #1;
    chk(tag, ph, mab, st);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_rdy = 1'b1;
    instr   = 16'hC000;
    #1 rst = 1'b0;
    #2;
    chk("reset_idle", ST_RSTV, MAB_RST, S_NONE);
    @(negedge clk);
    chk("reset_held", ST_RSTV, MAB_RST, S_NONE);

    // Reset vector fetch
    rst = 1'b1;
    cyc(1, 0, 16'hC000, "rstv_vec",  ST_RSTV,  MAB_RST, S_VEC);

    // MOV R5,R6
    cyc(1, 0, 16'h4506, "mov_fetch", ST_FETCH,  MAB_PC, S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "mov_dec",   ST_DECODE, MAB_PC, S_NONE);
    cyc(1, 0, 16'h0000, "mov_exec",  ST_EXEC,   MAB_PC, S_RW | S_DONE);

    // ADD #0x1234,&0x0200
    cyc(1, 0, 16'h50B2, "add_fetch", ST_FETCH,   MAB_PC,   S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "add_dec",   ST_DECODE,  MAB_PC,   S_NONE);
    cyc(1, 0, 16'h1234, "add_sext",  ST_SRC_EXT, MAB_PC,   S_EXT | S_PCI);
    cyc(1, 0, 16'h0200, "add_dext",  ST_DST_EXT, MAB_PC,   S_EXT | S_PCI);
    cyc(1, 0, 16'h0007, "add_drd",   ST_DST_RD,  MAB_CALC, S_NONE);
    cyc(1, 0, 16'h0000, "add_exec",  ST_EXEC,    MAB_PC,   S_NONE);
    cyc(1, 0, 16'h0000, "add_dwr",   ST_DST_WR,  MAB_CALC, S_MW | S_DONE);

    // CMP #0x1234,&0x0200: retires from EXEC with no write at all
    cyc(1, 0, 16'h90B2, "cmp_fetch", ST_FETCH,   MAB_PC,   S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "cmp_dec",   ST_DECODE,  MAB_PC,   S_NONE);
    cyc(1, 0, 16'h1234, "cmp_sext",  ST_SRC_EXT, MAB_PC,   S_EXT | S_PCI);
    cyc(1, 0, 16'h0200, "cmp_dext",  ST_DST_EXT, MAB_PC,   S_EXT | S_PCI);
    cyc(1, 0, 16'h0007, "cmp_drd",   ST_DST_RD,  MAB_CALC, S_NONE);
    cyc(1, 0, 16'h0000, "cmp_exec",  ST_EXEC,    MAB_PC,   S_DONE);

    // MOV @R5,R6: SRC_RD stalls, then times out on the 8th stalled cycle
    cyc(1, 0, 16'h4526, "ind_fetch", ST_FETCH,  MAB_PC, S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "ind_dec",   ST_DECODE, MAB_PC, S_NONE);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 16'h0000, $sformatf("srd_stall%0d", i), ST_SRC_RD, MAB_SOUT, S_NONE);
    end
    cyc(0, 0, 16'h0000, "srd_timeout", ST_SRC_RD, MAB_SOUT, S_BERR);
    cyc(0, 0, 16'h0000, "berr_fetch",  ST_FETCH,  MAB_PC,   S_NONE);

    // MOV @R5+,R6: counter restarted after bus error; autoincrement on read
    cyc(1, 0, 16'h4536, "ai_fetch", ST_FETCH,  MAB_PC,   S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "ai_dec",   ST_DECODE, MAB_PC,   S_NONE);
    cyc(0, 0, 16'h0000, "ai_stall", ST_SRC_RD, MAB_SOUT, S_NONE);
    cyc(1, 0, 16'h0055, "ai_rd",    ST_SRC_RD, MAB_SOUT, S_AI);
    cyc(1, 0, 16'h0000, "ai_exec",  ST_EXEC,   MAB_PC,   S_RW | S_DONE);

    // MOV R5,&0x0200: MOV skips the destination read
    cyc(1, 0, 16'h4582, "mova_fetch", ST_FETCH,   MAB_PC,   S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "mova_dec",   ST_DECODE,  MAB_PC,   S_NONE);
    cyc(1, 0, 16'h0200, "mova_dext",  ST_DST_EXT, MAB_PC,   S_EXT | S_PCI);
    cyc(1, 0, 16'h0000, "mova_exec",  ST_EXEC,    MAB_PC,   S_NONE);
    cyc(0, 0, 16'h0000, "mova_wstal", ST_DST_WR,  MAB_CALC, S_NONE);
    cyc(1, 0, 16'h0000, "mova_dwr",   ST_DST_WR,  MAB_CALC, S_MW | S_DONE);

    // RRC R5: format II register operand
    cyc(1, 0, 16'h1005, "rrc_fetch", ST_FETCH,  MAB_PC, S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "rrc_dec",   ST_DECODE, MAB_PC, S_NONE);
    cyc(1, 0, 16'h0000, "rrc_exec",  ST_EXEC,   MAB_PC, S_RW | S_DONE);

    // halt_req ignored in DECODE, honoured at retire
    cyc(1, 0, 16'h4506, "hlt_fetch", ST_FETCH,  MAB_PC, S_IR | S_PCI);
    cyc(1, 1, 16'h0000, "hlt_dec",   ST_DECODE, MAB_PC, S_NONE);
    cyc(1, 1, 16'h0000, "hlt_exec",  ST_EXEC,   MAB_PC, S_RW | S_DONE);
    cyc(1, 1, 16'h0000, "hlt_park",  ST_HALT,   MAB_PC, S_HALT);
    cyc(1, 0, 16'h0000, "hlt_drop",  ST_HALT,   MAB_PC, S_HALT);
    cyc(1, 0, 16'h4506, "hlt_leave", ST_FETCH,  MAB_PC, S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "hlt_dec2",  ST_DECODE, MAB_PC, S_NONE);
    cyc(1, 0, 16'h0000, "hlt_exec2", ST_EXEC,   MAB_PC, S_RW | S_DONE);

    // Reset asserted while in DST_RD
    cyc(1, 0, 16'h50B2, "rmid_fetch", ST_FETCH,   MAB_PC, S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "rmid_dec",   ST_DECODE,  MAB_PC, S_NONE);
    cyc(1, 0, 16'h1234, "rmid_sext",  ST_SRC_EXT, MAB_PC, S_EXT | S_PCI);
    cyc(1, 0, 16'h0200, "rmid_dext",  ST_DST_EXT, MAB_PC, S_EXT | S_PCI);
    rst = 1'b0;
    cyc(1, 0, 16'h0000, "rmid_rst",   ST_RSTV,    MAB_RST, S_NONE);
    cyc(1, 0, 16'h0000, "rmid_hold",  ST_RSTV,    MAB_RST, S_NONE);
    rst = 1'b1;
    cyc(1, 0, 16'hC000, "rmid_vec",   ST_RSTV,    MAB_RST, S_VEC);

    // CALL R0 is unsupported
    cyc(1, 0, 16'h1280, "call_fetch", ST_FETCH,  MAB_PC, S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "call_dec",   ST_DECODE, MAB_PC, S_ILL);

    // JMP $+12
    cyc(1, 0, 16'h3C05, "jmp_fetch", ST_FETCH,  MAB_PC, S_IR | S_PCI);
    cyc(1, 0, 16'h0000, "jmp_dec",   ST_DECODE, MAB_PC, S_NONE);
    cyc(1, 0, 16'h0000, "jmp_exec",  ST_EXEC,   MAB_PC, S_JMP | S_DONE);
    cyc(0, 0, 16'h0000, "jmp_next",  ST_FETCH,  MAB_PC, S_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
